// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared types and helpers for the dual-issue queue
// Purpose: functional-unit encoding, decoded instruction packet and the
//          load-use hazard helper used by the pairing logic.
// Ports:   none (package).
package issue_pkg;

  localparam int PAYLOAD_W = 96;

  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_BR  = 3'd1,
    FU_LD  = 3'd2,
    FU_ST  = 3'd3,
    FU_MUL = 3'd4,
    FU_DIV = 3'd5
  } fu_t;

  typedef struct packed {
    logic [31:0]          pc;
    logic [4:0]           raddr1;
    logic [4:0]           raddr2;
    logic [4:0]           waddr;
    logic                 rf_we;
    fu_t                  fu;
    logic [PAYLOAD_W-1:0] payload;
  } inst_pkt_t;

  // Source-side view of a candidate: the only fields the pairing logic reads.
  typedef struct packed {
    logic [4:0] raddr1;
    logic [4:0] raddr2;
    fu_t        fu;
  } src_view_t;

  // Lane B of the previous issue carries the only results that MEM cannot
  // forward (load data, multiply, divide); a reader of them must wait.
  function automatic logic load_use(src_view_t x, logic prev_valid, fu_t prev_fu,
                                    logic prev_rf_we, logic [4:0] prev_waddr);
    logic long_lat;
    long_lat = (prev_fu == FU_LD) || (prev_fu == FU_MUL) || (prev_fu == FU_DIV);
    return prev_valid && long_lat && prev_rf_we && (prev_waddr != 5'd0) &&
           ((x.raddr1 == prev_waddr) || (x.raddr2 == prev_waddr));
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// rtl/issue_queue_if.sv - decode/execute facing bus of the issue queue
// Purpose: bundles the enqueue handshake, stall/flush controls and the
//          registered ID/EX lane outputs.
// Ports:   master = decode + execution side (drives in_*, stall, flush);
//          slave  = issue queue (drives in_ready, out_*, count).
interface issue_queue_if #(parameter int DEPTH = 8);
  import issue_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid0;
  logic          in_valid1;
  inst_pkt_t     in_pkt0;
  inst_pkt_t     in_pkt1;
  logic          in_ready;
  logic          stall;
  logic          flush;
  logic          out_valid_a;
  logic          out_valid_b;
  inst_pkt_t     out_pkt_a;
  inst_pkt_t     out_pkt_b;
  logic [CW-1:0] count;

  modport master (
    output in_valid0, in_valid1, in_pkt0, in_pkt1, stall, flush,
    input  in_ready, out_valid_a, out_valid_b, out_pkt_a, out_pkt_b, count
  );

  modport slave (
    input  in_valid0, in_valid1, in_pkt0, in_pkt1, stall, flush,
    output in_ready, out_valid_a, out_valid_b, out_pkt_a, out_pkt_b, count
  );

endinterface

// File: rtl/issue_pair_check.sv
// rtl/issue_pair_check.sv - combinational pairing and hazard selection
// Purpose: decides what issues this cycle from the two oldest entries.
// Ports:   c0/c1 source views with valids, c0 destination, previous lane B
//          destination info; outputs issue_a, issue_b, sel_b_from_c0, deq.
module issue_pair_check
  import issue_pkg::*;
(
  input  src_view_t  c0,
  input  logic       c0_valid,
  input  logic [4:0] c0_waddr,
  input  logic       c0_rf_we,
  input  src_view_t  c1,
  input  logic       c1_valid,
  input  logic       prev_valid,
  input  fu_t        prev_fu,
  input  logic       prev_rf_we,
  input  logic [4:0] prev_waddr,
  output logic       issue_a,
  output logic       issue_b,
  output logic       sel_b_from_c0,
  output logic [1:0] deq
);

  logic hz0;
  logic hz1;
  logic raw;
  logic both_br;
  logic c0_lane_a_ok;

  assign hz0 = load_use(c0, prev_valid, prev_fu, prev_rf_we, prev_waddr);
  assign hz1 = load_use(c1, prev_valid, prev_fu, prev_rf_we, prev_waddr);

  // Same-cycle lanes cannot forward A->B, so a B reader of A's result waits.
  assign raw = c0_rf_we && (c0_waddr != 5'd0) &&
               ((c1.raddr1 == c0_waddr) || (c1.raddr2 == c0_waddr));

  assign both_br      = (c0.fu == FU_BR) && (c1.fu == FU_BR);
  assign c0_lane_a_ok = (c0.fu == FU_ALU) || (c0.fu == FU_BR);

  always_comb begin
    issue_a       = 1'b0;
    issue_b       = 1'b0;
    sel_b_from_c0 = 1'b0;
    deq           = 2'd0;
    if (c0_valid && !hz0) begin
      if (c0_lane_a_ok) begin
        issue_a = 1'b1;
        deq     = 2'd1;
        if (c1_valid && !hz1 && !raw && !both_br) begin
          issue_b = 1'b1;
          deq     = 2'd2;
        end
      end else begin
        // Memory and long-latency units only exist behind lane B.
        issue_b       = 1'b1;
        sel_b_from_c0 = 1'b1;
        deq           = 2'd1;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - dual-issue instruction FIFO and ID/EX pairing stage
// Purpose: buffers up to two decoded instructions per cycle and issues up to
//          two in-order instructions into lanes A/B through registered outputs.
// Ports:   clk, rstn (async active-low); bus (issue_queue_if.slave) carrying
//          in_valid0/1, in_pkt0/1, in_ready, stall, flush, out_valid_a/b,
//          out_pkt_a/b and count.
module issue_queue
  import issue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rstn,
  issue_queue_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  inst_pkt_t     mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic          out_valid_a;
  logic          out_valid_b;
  inst_pkt_t     out_pkt_a;
  inst_pkt_t     out_pkt_b;

  logic          in_ready;
  logic          enq;
  logic [1:0]    n_enq;
  logic [1:0]    deq_eff;

  inst_pkt_t     c0;
  inst_pkt_t     c1;
  src_view_t     c0_src;
  src_view_t     c1_src;
  logic          c0_valid;
  logic          c1_valid;

  logic          issue_a;
  logic          issue_b;
  logic          sel_b_from_c0;
  logic [1:0]    deq;

  assign in_ready = (count <= CW'(DEPTH - 2));
  assign enq      = in_ready && bus.in_valid0;
  assign n_enq    = enq ? (bus.in_valid1 ? 2'd2 : 2'd1) : 2'd0;

  assign c0       = mem[head];
  assign c1       = mem[head + AW'(1)];
  assign c0_valid = (count != '0);
  assign c1_valid = (count > CW'(1));

  assign c0_src   = '{raddr1: c0.raddr1, raddr2: c0.raddr2, fu: c0.fu};
  assign c1_src   = '{raddr1: c1.raddr1, raddr2: c1.raddr2, fu: c1.fu};

  issue_pair_check u_pair_check (
    .c0            (c0_src),
    .c0_valid      (c0_valid),
    .c0_waddr      (c0.waddr),
    .c0_rf_we      (c0.rf_we),
    .c1            (c1_src),
    .c1_valid      (c1_valid),
    .prev_valid    (out_valid_b),
    .prev_fu       (out_pkt_b.fu),
    .prev_rf_we    (out_pkt_b.rf_we),
    .prev_waddr    (out_pkt_b.waddr),
    .issue_a       (issue_a),
    .issue_b       (issue_b),
    .sel_b_from_c0 (sel_b_from_c0),
    .deq           (deq)
  );

  assign deq_eff = bus.stall ? 2'd0 : deq;

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (enq && !bus.flush) begin
      mem[tail] <= bus.in_pkt0;
      if (bus.in_valid1) begin
        mem[tail + AW'(1)] <= bus.in_pkt1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      out_valid_a <= 1'b0;
      out_valid_b <= 1'b0;
      out_pkt_a   <= '0;
      out_pkt_b   <= '0;
    end else if (bus.flush) begin
      // Packets are left as they are; the cleared valids make them inert.
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      out_valid_a <= 1'b0;
      out_valid_b <= 1'b0;
    end else begin
      tail  <= tail + AW'(n_enq);
      count <= count + CW'(n_enq) - CW'(deq_eff);
      if (!bus.stall) begin
        head        <= head + AW'(deq);
        out_valid_a <= issue_a;
        out_valid_b <= issue_b;
        if (issue_a) begin
          out_pkt_a <= c0;
        end
        if (issue_b) begin
          out_pkt_b <= sel_b_from_c0 ? c0 : c1;
        end
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid_a = out_valid_a;
  assign bus.out_valid_b = out_valid_b;
  assign bus.out_pkt_a   = out_pkt_a;
  assign bus.out_pkt_b   = out_pkt_b;
  assign bus.count       = count;

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - directed table-driven bench for issue_queue
module tb_issue_queue;
  import issue_pkg::*;

  localparam int DEPTH = 8;

  logic clk;
  logic rstn;

  issue_queue_if #(.DEPTH(DEPTH)) bus ();

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  typedef struct {
    string     name;
    logic      v0;
    inst_pkt_t p0;
    logic      v1;
    inst_pkt_t p1;
    logic      st;
    logic      fl;
    int        e_cnt;
    logic      e_rdy;
    logic      e_va;
    inst_pkt_t e_pa;
    logic      e_vb;
    inst_pkt_t e_pb;
  } row_t;

  row_t rows[$];
  int   tests;
  int   fails;

  function automatic inst_pkt_t mk(logic [31:0] pc, fu_t fu, logic [4:0] w, logic we,
                                   logic [4:0] r1, logic [4:0] r2);
    inst_pkt_t p;
    p.pc      = pc;
    p.raddr1  = r1;
    p.raddr2  = r2;
    p.waddr   = w;
    p.rf_we   = we;
    p.fu      = fu;
    p.payload = {pc, ~pc, pc ^ 32'h5a5a_5a5a};
    return p;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic v0, input inst_pkt_t p0,
                     input logic v1, input inst_pkt_t p1, input logic st, input logic fl,
                     input int e_cnt, input logic e_rdy, input logic e_va, input inst_pkt_t e_pa,
                     input logic e_vb, input inst_pkt_t e_pb);
    row_t r;
    r.name = name; r.v0 = v0; r.p0 = p0; r.v1 = v1; r.p1 = p1; r.st = st; r.fl = fl;
    r.e_cnt = e_cnt; r.e_rdy = e_rdy; r.e_va = e_va; r.e_pa = e_pa; r.e_vb = e_vb; r.e_pb = e_pb;
    rows.push_back(r);
  endtask

  task automatic drive(input logic v0, input inst_pkt_t p0, input logic v1, input inst_pkt_t p1,
                       input logic st, input logic fl);
    bus.in_valid0 = v0;
    bus.in_pkt0   = p0;
    bus.in_valid1 = v1;
    bus.in_pkt1   = p1;
    bus.stall     = st;
    bus.flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input int cnt, input logic rdy,
                           input logic va, input inst_pkt_t pa, input logic vb, input inst_pkt_t pb);
    check({name, ".count"}, 160'(bus.count), 160'(cnt));
    check({name, ".in_ready"}, 160'(bus.in_ready), 160'(rdy));
    check({name, ".valid_a"}, 160'(bus.out_valid_a), 160'(va));
    check({name, ".valid_b"}, 160'(bus.out_valid_b), 160'(vb));
    if (va) check({name, ".pkt_a"}, 160'(bus.out_pkt_a), 160'(pa));
    if (vb) check({name, ".pkt_b"}, 160'(bus.out_pkt_b), 160'(pb));
  endtask

  inst_pkt_t z;
  inst_pkt_t a1, a2, b1, b2, c1, c2, d0, d1, f1, f2, g1, g2;
  inst_pkt_t e[8];
  inst_pkt_t h[11];

  initial begin
    tests = 0;
    fails = 0;
    z  = '0;
    a1 = mk(32'h100, FU_ALU, 5'd5, 1'b1, 5'd1, 5'd0);
    a2 = mk(32'h104, FU_ALU, 5'd6, 1'b1, 5'd2, 5'd0);
    b1 = mk(32'h200, FU_ALU, 5'd5, 1'b1, 5'd1, 5'd0);
    b2 = mk(32'h204, FU_ALU, 5'd7, 1'b1, 5'd5, 5'd0);
    c1 = mk(32'h300, FU_LD,  5'd8, 1'b1, 5'd2, 5'd0);
    c2 = mk(32'h304, FU_ALU, 5'd9, 1'b1, 5'd8, 5'd0);
    d0 = mk(32'h400, FU_ALU, 5'd10, 1'b1, 5'd1, 5'd0);
    d1 = mk(32'h404, FU_ALU, 5'd11, 1'b1, 5'd2, 5'd0);
    for (int i = 0; i < 8; i++) e[i] = mk(32'h410 + 32'(4 * i), FU_ALU, 5'(12 + i), 1'b1, 5'd1, 5'd2);
    f1 = mk(32'h600, FU_BR,  5'd0, 1'b0, 5'd1, 5'd2);
    f2 = mk(32'h604, FU_BR,  5'd0, 1'b0, 5'd3, 5'd0);
    g1 = mk(32'h610, FU_ALU, 5'd3, 1'b1, 5'd1, 5'd0);
    g2 = mk(32'h614, FU_DIV, 5'd4, 1'b1, 5'd3, 5'd0);
    for (int i = 0; i < 11; i++) h[i] = mk(32'h500 + 32'(4 * i), FU_ALU, 5'(20 + i), 1'b1, 5'd1, 5'd2);

    // Independent ALU pair dual-issues.
    add("s1_push",  1, a1, 1, a2, 0, 0, 2, 1, 0, z, 0, z);
    add("s1_issue", 0, z,  0, z,  0, 0, 0, 1, 1, a1, 1, a2);
    add("s1_idle",  0, z,  0, z,  0, 0, 0, 1, 0, z, 0, z);
    // RAW inside the pair splits it.
    add("s2_push",  1, b1, 1, b2, 0, 0, 2, 1, 0, z, 0, z);
    add("s2_raw",   0, z,  0, z,  0, 0, 1, 1, 1, b1, 0, z);
    add("s2_second",0, z,  0, z,  0, 0, 0, 1, 1, b2, 0, z);
    add("s2_idle",  0, z,  0, z,  0, 0, 0, 1, 0, z, 0, z);
    // Load goes to lane B, then its consumer waits one bubble.
    add("s3_push",  1, c1, 1, c2, 0, 0, 2, 1, 0, z, 0, z);
    add("s3_ld",    0, z,  0, z,  0, 0, 1, 1, 0, z, 1, c1);
    add("s3_luse",  0, z,  0, z,  0, 0, 1, 1, 0, z, 0, z);
    add("s3_alu",   0, z,  0, z,  0, 0, 0, 1, 1, c2, 0, z);
    add("s3_idle",  0, z,  0, z,  0, 0, 0, 1, 0, z, 0, z);
    // Stall holds outputs, fills to DEPTH, drops pushes when not ready.
    add("s4_push0", 1, d0,   1, d1,   0, 0, 2, 1, 0, z, 0, z);
    add("s4_push1", 1, e[0], 1, e[1], 0, 0, 2, 1, 1, d0, 1, d1);
    add("s4_st1",   1, e[2], 1, e[3], 1, 0, 4, 1, 1, d0, 1, d1);
    add("s4_st2",   1, e[4], 1, e[5], 1, 0, 6, 1, 1, d0, 1, d1);
    add("s4_st3",   1, e[6], 1, e[7], 1, 0, 8, 0, 1, d0, 1, d1);
    add("s4_full",  1, d0,   1, d1,   1, 0, 8, 0, 1, d0, 1, d1);
    add("s4_rel1",  0, z, 0, z, 0, 0, 6, 1, 1, e[0], 1, e[1]);
    add("s4_rel2",  0, z, 0, z, 0, 0, 4, 1, 1, e[2], 1, e[3]);
    add("s4_rel3",  0, z, 0, z, 0, 0, 2, 1, 1, e[4], 1, e[5]);
    add("s4_rel4",  0, z, 0, z, 0, 0, 0, 1, 1, e[6], 1, e[7]);
    add("s4_idle",  0, z, 0, z, 0, 0, 0, 1, 0, z, 0, z);
    // Two branches never pair; DIV waits for RAW then goes to lane B alone.
    add("s6_pushbr",0, z, 0, z, 0, 0, 0, 1, 0, z, 0, z);
    rows[$].v0 = 1; rows[$].p0 = f1; rows[$].v1 = 1; rows[$].p1 = f2; rows[$].e_cnt = 2;
    add("s6_br1",   0, z,  0, z,  0, 0, 1, 1, 1, f1, 0, z);
    add("s6_br2",   0, z,  0, z,  0, 0, 0, 1, 1, f2, 0, z);
    add("s6_pushdv",1, g1, 1, g2, 0, 0, 2, 1, 0, z, 0, z);
    add("s6_raw",   0, z,  0, z,  0, 0, 1, 1, 1, g1, 0, z);
    add("s6_div",   0, z,  0, z,  0, 0, 0, 1, 0, z, 1, g2);
    add("s6_idle",  0, z,  0, z,  0, 0, 0, 1, 0, z, 0, z);

    // Reset state.
    rstn = 1'b0;
    drive(0, z, 0, z, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 0, 1, 0, z, 0, z);
    check("reset.pkt_a_zero", 160'(bus.out_pkt_a), 160'(0));
    check("reset.pkt_b_zero", 160'(bus.out_pkt_b), 160'(0));
    rstn = 1'b1;

    foreach (rows[i]) begin
      drive(rows[i].v0, rows[i].p0, rows[i].v1, rows[i].p1, rows[i].st, rows[i].fl);
      tick();
      chk_state(rows[i].name, rows[i].e_cnt, rows[i].e_rdy, rows[i].e_va, rows[i].e_pa,
                rows[i].e_vb, rows[i].e_pb);
    end

    // Flush beats stall and a same-cycle push.
    drive(1, h[0], 1, h[1], 0, 0); tick();
    chk_state("f_push", 2, 1, 0, z, 0, z);
    drive(0, z, 0, z, 0, 0); tick();
    chk_state("f_issue", 0, 1, 1, h[0], 1, h[1]);
    drive(1, h[2], 1, h[3], 1, 0); tick();
    chk_state("f_fill2", 2, 1, 1, h[0], 1, h[1]);
    drive(1, h[4], 1, h[5], 1, 0); tick();
    chk_state("f_fill4", 4, 1, 1, h[0], 1, h[1]);
    drive(1, h[6], 0, z, 1, 0); tick();
    chk_state("f_fill5", 5, 1, 1, h[0], 1, h[1]);
    drive(1, h[7], 1, h[8], 1, 1); tick();
    chk_state("f_flush", 0, 1, 0, z, 0, z);
    drive(0, z, 0, z, 0, 0); tick();
    chk_state("f_after", 0, 1, 0, z, 0, z);
    drive(1, h[9], 1, h[10], 0, 0); tick();
    chk_state("f_repush", 2, 1, 0, z, 0, z);
    drive(0, z, 0, z, 0, 0); tick();
    chk_state("f_reissue", 0, 1, 1, h[9], 1, h[10]);

    // Asynchronous reset in mid-operation.
    drive(1, a1, 1, a2, 0, 0); tick();
    drive(0, z, 0, z, 0, 0); tick();
    chk_state("r_live", 0, 1, 1, a1, 1, a2);
    drive(1, h[2], 1, h[3], 0, 0); tick();
    drive(0, z, 0, z, 0, 0);
    #3;
    rstn = 1'b0;
    #1;
    chk_state("r_async", 0, 1, 0, z, 0, z);
    check("r_async.pkt_a_zero", 160'(bus.out_pkt_a), 160'(0));
    check("r_async.pkt_b_zero", 160'(bus.out_pkt_b), 160'(0));
    tick();
    rstn = 1'b1;
    tick();
    chk_state("r_release", 0, 1, 0, z, 0, z);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
